// File: rtl/mem_writer.sv
// mem_writer: write-side controller for the parallel-read memory.
//
// Accepts signed words over a valid/ready stream and writes them to consecutive
// memory addresses starting at 0. Once the last word has reached the memory's
// registered parallel output, load_done is raised. New input is then refused
// until the consumer pulses release_buf_i.
//
// Optional feature: define MEM_WRITER_LAST_EN to add s_last_i. A handshake with
// s_last_i=1 ends the load early.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   s_valid_i      input word offered
//   s_ready_o      word accepted this cycle (depends on state only)
//   s_data_i       signed input word
//   s_last_i       final word of a short load (MEM_WRITER_LAST_EN only)
//   release_buf_i  consumer done with buffer, start a new load (FULL only)
//   wr_data_o      memory data_in (registered)
//   wr_addr_o      memory addr (registered)
//   wr_en_o        memory wr_en (registered)
//   load_done_o    whole load visible on the memory's parallel output
//   load_count_o   words written in the current or completed load

module mem_writer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SIZE    = 64,
  parameter int unsigned LOGSIZE = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [WIDTH-1:0]   s_data_i,
`ifdef MEM_WRITER_LAST_EN
  input  logic               s_last_i,
`endif
  input  logic               release_buf_i,
  output logic [WIDTH-1:0]   wr_data_o,
  output logic [LOGSIZE-1:0] wr_addr_o,
  output logic               wr_en_o,
  output logic               load_done_o,
  output logic [LOGSIZE:0]   load_count_o
);

  typedef enum logic [1:0] {StLoad, StDrain, StFull} state_e;

  localparam logic [LOGSIZE-1:0] PtrLast = LOGSIZE'(SIZE - 1);
  localparam logic [LOGSIZE-1:0] PtrOne  = LOGSIZE'(1);
  localparam logic [LOGSIZE:0]   CntOne  = (LOGSIZE + 1)'(1);

  state_e               state_q, state_d;
  logic [LOGSIZE-1:0]   ptr_q, ptr_d;
  logic [LOGSIZE:0]     cnt_q, cnt_d;
  logic                 drain_q, drain_d;
  // Keeps s_ready low for the first cycle after reset is released.
  logic                 arm_q;
  logic [WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [LOGSIZE-1:0]   wr_addr_q, wr_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic                 done_q, done_d;
  logic                 hs;
  logic                 last_word;

  assign s_ready_o = (state_q == StLoad) && arm_q;
  assign hs        = s_valid_i && s_ready_o;

`ifdef MEM_WRITER_LAST_EN
  assign last_word = (ptr_q == PtrLast) || s_last_i;
`else
  assign last_word = (ptr_q == PtrLast);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    // Registered one cycle behind FULL so it rises only after the parallel
    // output register has captured the final write.
    done_d    = (state_q == StFull) && !release_buf_i;

    unique case (state_q)
      StLoad: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = s_data_i;
          cnt_d     = cnt_q + CntOne;
          if (last_word) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end else begin
            ptr_d = ptr_q + PtrOne;
          end
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (release_buf_i) begin
          state_d = StLoad;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StLoad;
      ptr_q     <= '0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      arm_q     <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      arm_q     <= 1'b1;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
    end
  end

  assign wr_data_o    = wr_data_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_en_o      = wr_en_q;
  assign load_done_o  = done_q;
  assign load_count_o = cnt_q;

endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: the driver queues each expected write on
// a handshake, and a monitor checks every wr_en cycle against that queue.

module tb_mem_writer;
  localparam int W  = 16;
  localparam int SZ = 64;
  localparam int LS = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          release_buf = 1'b0;
  logic [W-1:0]  wr_data;
  logic [LS-1:0] wr_addr;
  logic          wr_en;
  logic          load_done;
  logic [LS:0]   load_count;

  always #5 clk = ~clk;

  mem_writer #(.WIDTH(W), .SIZE(SZ), .LOGSIZE(LS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
`ifdef MEM_WRITER_LAST_EN
    .s_last_i     (s_last),
`endif
    .release_buf_i(release_buf),
    .wr_data_o    (wr_data),
    .wr_addr_o    (wr_addr),
    .wr_en_o      (wr_en),
    .load_done_o  (load_done),
    .load_count_o (load_count)
  );

  // Memory model: write port plus registered parallel output.
  logic [SZ-1:0][W-1:0] mem;
  logic [SZ-1:0][W-1:0] mem_out;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    mem_out <= mem;
  end

  int n_vec = 0;
  int n_err = 0;
  int stalls = 0;
  int exp_ptr = 0;
  logic [W-1:0] exp_mem [SZ];
  logic [LS+W-1:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding handshake.
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      if (sb_q.size() == 0) begin
        chk("spurious_wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        logic [LS+W-1:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[LS+W-1:W]));
        chk("wr_data", 32'(wr_data), 32'(e[W-1:0]));
      end
    end
  end

  // Offer one word; idle cycles first when bubble is set. rel pulses
  // release_buf on the offering cycle.
  task automatic send(input logic [W-1:0] d, input bit last, input bit bubble, input bit rel);
    bit hs;
    int tries;
    if (bubble && ($urandom_range(0, 1) == 1)) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    release_buf = rel;
    hs = 1'b0;
    tries = 0;
    while (!hs && tries < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      if (hs) begin
        sb_q.push_back({LS'(exp_ptr), d});
        exp_mem[exp_ptr] = d;
        exp_ptr++;
      end else begin
        stalls++;
      end
      #1;
      release_buf = 1'b0;
      tries++;
    end
    if (!hs) chk("send_timeout", 32'(tries), 32'(0));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called right after the final handshake edge (+1): done must appear 3 edges later.
  task automatic wait_done(input int exp_cnt);
    int n;
    n = 0;
    while (!load_done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", 32'(n), 32'(3));
    chk("load_count", 32'(load_count), 32'(exp_cnt));
    chk("s_ready_full", 32'(s_ready), 32'(0));
    for (int i = 0; i < SZ; i++) begin
      if (mem_out[i] !== exp_mem[i]) chk("mem_out", 32'(mem_out[i]), 32'(exp_mem[i]));
    end
    n_vec++;  // whole-memory compare
  endtask

  task automatic do_release();
    release_buf = 1'b1;
    @(posedge clk); #1;
    release_buf = 1'b0;
    exp_ptr = 0;
    chk("rel_done", 32'(load_done), 32'(0));
    chk("rel_ready", 32'(s_ready), 32'(1));
    chk("rel_count", 32'(load_count), 32'(0));
  endtask

  initial begin
    // Reset values.
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    chk("rst_done", 32'(load_done), 32'(0));
    chk("rst_count", 32'(load_count), 32'(0));
    reset_n = 1'b1;
    #1 chk("ready_first_cycle", 32'(s_ready), 32'(0));
    @(posedge clk); #1;
    chk("ready_after_arm", 32'(s_ready), 32'(1));

    // Reset mid-load.
    for (int i = 0; i < 30; i++) send(W'(i + 1), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 chk("sb_empty_pre_rst", 32'(sb_q.size()), 32'(0));
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'(0));
    chk("abort_count", 32'(load_count), 32'(0));
    chk("abort_done", 32'(load_done), 32'(0));
    chk("abort_ready", 32'(s_ready), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_ptr = 0;
    @(posedge clk); #1;
    chk("abort_ready_back", 32'(s_ready), 32'(1));

    // Full load, back-to-back.
    stalls = 0;
    for (int i = 0; i < SZ; i++) send(W'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("no_stalls", 32'(stalls), 32'(0));
    wait_done(SZ);

    // FULL: s_valid held, nothing accepted; early release ignored.
    s_valid = 1'b1;
    s_data  = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_hold_ready", 32'(s_ready), 32'(0));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("full_hold_count", 32'(load_count), 32'(SZ));
    do_release();

    // Negative values with a release pulse at word 20 (ignored).
    for (int i = 0; i < SZ; i++) send(W'(-(i + 1)), 1'b0, 1'b0, i == 20);
    wait_done(SZ);
    do_release();

    // Bubbles.
    for (int i = 0; i < SZ; i++) send(W'(i + 1), 1'b0, 1'b1, 1'b0);
    wait_done(SZ);

`ifdef MEM_WRITER_LAST_EN
    do_release();
    for (int i = 0; i < 5; i++) send(W'(16'h100 + i), i == 4, 1'b0, 1'b0);
    wait_done(5);
`endif

    repeat (3) @(posedge clk);
    #1 chk("sb_empty_end", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
